// File: rtl/pbuf_pkg.sv
// ============================================================================
// pbuf_pkg: shared register map, status/control bit positions and FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package pbuf_pkg;

    localparam logic [15:0] PBUF_CTRL_ADDR = 16'h4000;
    localparam logic [15:0] PBUF_LEN_ADDR  = 16'h4001;

    localparam int ST_BACK_SEL = 0;
    localparam int ST_PLAY     = 1;
    localparam int ST_PENDING  = 2;
    localparam int ST_UNDERRUN = 3;
    localparam int ST_WR_ERR   = 4;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_CLEAR  = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } pbuf_state_t;

endpackage

`default_nettype wire

// File: rtl/pbuf_bank.sv
// ============================================================================
// pbuf_bank: single sample bank, one write port and one registered read port
// Rev 1.0
// ============================================================================
`default_nettype none

module pbuf_bank #(
    parameter int DATA_WIDTH = 12,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

`default_nettype wire

// File: rtl/dual_playback_buffer.sv
// ============================================================================
// dual_playback_buffer: ping-pong DAC playback buffer filled over the MCU bus
// Build option PBUF_IRQ_EN adds an irq pulse on every swap / underrun wrap. Rev 1.0
// ============================================================================
`default_nettype none

module dual_playback_buffer
    import pbuf_pkg::*;
#(
    parameter int                    DATA_WIDTH = 12,
    parameter int                    BUF_SIZE   = 1024,
    parameter logic [15:0]           CTRL_ADDR  = PBUF_CTRL_ADDR,
    parameter logic [15:0]           LEN_ADDR   = PBUF_LEN_ADDR,
    parameter logic [DATA_WIDTH-1:0] IDLE_CODE  = 'h800
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  addr_en,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [15:0]           rd_data,
    output logic [15:0]           wr_data,
    input  logic                  dac_tick,
    output logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_valid
`ifdef PBUF_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int          AW         = $clog2(BUF_SIZE);
    localparam logic [AW:0] LEN_FULL   = (AW+1)'(BUF_SIZE);
    localparam logic [15:0] BUF_SIZE_W = 16'(BUF_SIZE);

    pbuf_state_t state, state_next;

    logic [15:0]           bus_addr;
    logic                  strobe_d;
    logic                  rd_p1, rd_p2;
    logic [15:0]           readback, readback_next;
    logic                  back_sel, pending, underrun, wr_err;
    logic [AW:0]           len, frame_len;
    logic [AW-1:0]         ptr;
    logic                  tick_d, tick_bank;
    logic [DATA_WIDTH-1:0] bank_dout [2];

    logic wr_pulse, is_ctrl, is_len, is_buf, ctrl_wr;
    logic ctrl_commit, ctrl_stop, ctrl_clear, buf_wr;
    logic play_tick, wrap, start, swap, underrun_wrap;

    assign wr_pulse      = en & rd_en & ~strobe_d;
    assign is_ctrl       = (bus_addr == CTRL_ADDR);
    assign is_len        = (bus_addr == LEN_ADDR);
    assign is_buf        = (bus_addr[15:AW] == '0);
    assign ctrl_wr       = wr_pulse & is_ctrl;
    assign ctrl_commit   = ctrl_wr & rd_data[CTRL_COMMIT];
    assign ctrl_stop     = ctrl_wr & rd_data[CTRL_STOP];
    assign ctrl_clear    = ctrl_wr & rd_data[CTRL_CLEAR];
    assign buf_wr        = wr_pulse & is_buf;
    assign play_tick     = (state == PLAY) & dac_tick & ~ctrl_stop;
    assign wrap          = play_tick & ({1'b0, ptr} == frame_len - (AW+1)'(1));
    assign start         = (state == IDLE) & pending & ~ctrl_stop;
    // Pending is sampled before this clock's commit lands, so a same-clock commit waits a frame
    assign swap          = start | (wrap & pending);
    assign underrun_wrap = wrap & ~pending;

    assign wr_data   = (en & wr_en) ? readback : '0;
    assign dac_valid = (state == PLAY);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic is_back;
        assign is_back = (back_sel == 1'(b));
        pbuf_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (BUF_SIZE),
            .ADDR_WIDTH (AW)
        ) u_bank (
            .clk   (clk),
            .we    (buf_wr & ~pending & is_back),
            .waddr (bus_addr[AW-1:0]),
            .wdata (rd_data[DATA_WIDTH-1:0]),
            .raddr (is_back ? bus_addr[AW-1:0] : ptr),
            .rdata (bank_dout[b])
        );
    end

    always_comb begin
        readback_next = '0;
        if (is_ctrl) begin
            readback_next[ST_BACK_SEL] = back_sel;
            readback_next[ST_PLAY]     = (state == PLAY);
            readback_next[ST_PENDING]  = pending;
            readback_next[ST_UNDERRUN] = underrun;
            readback_next[ST_WR_ERR]   = wr_err;
        end else if (is_len) begin
            readback_next = 16'(len);
        end else if (is_buf) begin
            readback_next = 16'(bank_dout[back_sel]);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = PLAY;
            PLAY:    if (ctrl_stop) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_addr  <= '0;
            strobe_d  <= 1'b0;
            rd_p1     <= 1'b0;
            rd_p2     <= 1'b0;
            readback  <= '0;
            back_sel  <= 1'b0;
            pending   <= 1'b0;
            underrun  <= 1'b0;
            wr_err    <= 1'b0;
            len       <= LEN_FULL;
            frame_len <= LEN_FULL;
            ptr       <= '0;
            tick_d    <= 1'b0;
            tick_bank <= 1'b0;
            dac_data  <= IDLE_CODE;
        end else begin
            strobe_d <= en & rd_en;
            if (en & addr_en) begin
                bus_addr <= rd_data;
            end
            // Readback captures two clocks after the address phase (RAM read sits between)
            rd_p1 <= en & addr_en;
            rd_p2 <= rd_p1;
            if (rd_p2) begin
                readback <= readback_next;
            end

            if (swap) begin
                back_sel <= ~back_sel;
            end
            if (swap) begin
                pending <= 1'b0;
            end else if (ctrl_commit) begin
                pending <= 1'b1;
            end
            if (underrun_wrap) begin
                underrun <= 1'b1;
            end else if (ctrl_clear) begin
                underrun <= 1'b0;
            end
            if (buf_wr & pending) begin
                wr_err <= 1'b1;
            end else if (ctrl_clear) begin
                wr_err <= 1'b0;
            end
            if (wr_pulse & is_len) begin
                len <= ((rd_data == '0) || (rd_data > BUF_SIZE_W)) ? LEN_FULL : rd_data[AW:0];
            end

            if (start | wrap) begin
                ptr       <= '0;
                frame_len <= len;
            end else if (play_tick) begin
                ptr <= ptr + AW'(1);
            end

            tick_d    <= play_tick;
            tick_bank <= ~back_sel;
            if (ctrl_stop) begin
                dac_data <= IDLE_CODE;
            end else if (tick_d && (state == PLAY)) begin
                dac_data <= bank_dout[tick_bank];
            end
        end
    end

`ifdef PBUF_IRQ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= swap | underrun_wrap;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dual_playback_buffer.sv
// ============================================================================
// tb_dual_playback_buffer: directed scoreboard bench for dual_playback_buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dual_playback_buffer;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b0;
    logic        addr_en  = 1'b0;
    logic        rd_en    = 1'b0;
    logic        wr_en    = 1'b0;
    logic        dac_tick = 1'b0;
    logic [15:0] rd_data  = '0;
    logic [15:0] wr_data;
    logic [11:0] dac_data;
    logic        dac_valid;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q [$];
    logic [15:0] rdv;

`ifdef PBUF_IRQ_EN
    logic irq;
    int   irq_cnt = 0;
    always @(posedge clk) if (irq === 1'b1) irq_cnt++;
`endif

    dual_playback_buffer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .addr_en   (addr_en),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .rd_data   (rd_data),
        .wr_data   (wr_data),
        .dac_tick  (dac_tick),
        .dac_data  (dac_data),
        .dac_valid (dac_valid)
`ifdef PBUF_IRQ_EN
        ,
        .irq       (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        en = 1'b1; addr_en = 1'b1; rd_data = a;
        cyc(1);
        addr_en = 1'b0; rd_en = 1'b1; rd_data = d;
        cyc(1);
        rd_en = 1'b0; en = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
        en = 1'b1; addr_en = 1'b1; rd_data = a;
        cyc(1);
        addr_en = 1'b0;
        cyc(2);
        wr_en = 1'b1;
        #1;
        rdv = wr_data;
        wr_en = 1'b0; en = 1'b0;
        check(tag, 32'(rdv), 32'(exp));
    endtask

    task automatic sb_check();
        logic [11:0] e;
        n_assert++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_underflow: observed sample %0h expected none", dac_data);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("dac_sample", 32'(dac_data), 32'(e));
        end
    endtask

    task automatic tick();
        dac_tick = 1'b1;
        cyc(1);
        dac_tick = 1'b0;
        cyc(1);
        sb_check();
    endtask

    initial begin
        // Reset state
        cyc(3);
        check("rst_dac_data", 32'(dac_data), 32'h800);
        check("rst_dac_valid", 32'(dac_valid), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        rst_n = 1'b1;
        cyc(1);
        read_check("rst_status", 16'h4000, 16'h0000);
        read_check("rst_len", 16'h4001, 16'h0400);

        // Bank0 = i, len 8, play 10 ticks with no refill -> underrun replay
        for (int i = 0; i < 8; i++) bus_write(16'(i), 16'(i));
        bus_write(16'h4001, 16'd8);
        bus_write(16'h4000, 16'h0001);
        read_check("play_status", 16'h4000, 16'h0003);
        check("play_valid", 32'(dac_valid), 32'h1);
        for (int i = 0; i < 10; i++) exp_q.push_back(12'(i % 8));
        repeat (10) tick();
        read_check("underrun_status", 16'h4000, 16'h000B);

        // Refill back bank mid-frame and commit: next frame starts at 100
        for (int i = 0; i < 8; i++) bus_write(16'(i), 16'(100 + i));
        bus_write(16'h4000, 16'h0001);
        read_check("pending_status", 16'h4000, 16'h000F);
        for (int i = 2; i < 8; i++) exp_q.push_back(12'(i));
        exp_q.push_back(12'd100);
        exp_q.push_back(12'd101);
        repeat (8) tick();
        read_check("swap_status", 16'h4000, 16'h000A);

        // Buffer write while pending is dropped and flags wr_err
        bus_write(16'h4000, 16'h0001);
        bus_write(16'd3, 16'd999);
        read_check("wr_err_status", 16'h4000, 16'h001E);
        read_check("dropped_word", 16'd3, 16'd3);
        bus_write(16'h4000, 16'h0004);
        read_check("cleared_status", 16'h4000, 16'h0006);
        for (int i = 102; i < 108; i++) exp_q.push_back(12'(i));
        exp_q.push_back(12'd0);
        repeat (7) tick();
        read_check("swap2_status", 16'h4000, 16'h0003);

        // Commit on the same clock as the wrap tick: old bank replays once
        for (int i = 1; i < 7; i++) exp_q.push_back(12'(i));
        repeat (6) tick();
        exp_q.push_back(12'd7);
        en = 1'b1; addr_en = 1'b1; rd_data = 16'h4000;
        cyc(1);
        addr_en = 1'b0; rd_en = 1'b1; rd_data = 16'h0001; dac_tick = 1'b1;
        cyc(1);
        rd_en = 1'b0; en = 1'b0; dac_tick = 1'b0;
        cyc(1);
        sb_check();
        read_check("late_commit_status", 16'h4000, 16'h000F);
        for (int i = 0; i < 8; i++) exp_q.push_back(12'(i));
        exp_q.push_back(12'd100);
        repeat (9) tick();

        // Stop at sample 3
        exp_q.push_back(12'd101);
        exp_q.push_back(12'd102);
        repeat (2) tick();
        bus_write(16'h4000, 16'h0002);
        check("stop_dac_data", 32'(dac_data), 32'h800);
        check("stop_dac_valid", 32'(dac_valid), 32'h0);
        dac_tick = 1'b1;
        cyc(1);
        dac_tick = 1'b0;
        cyc(1);
        check("idle_tick_data", 32'(dac_data), 32'h800);
        read_check("stop_status", 16'h4000, 16'h0008);

        // Reset mid-frame
        bus_write(16'h4000, 16'h0001);
        cyc(1);
        exp_q.push_back(12'd0);
        tick();
        rst_n = 1'b0; dac_tick = 1'b1;
        cyc(1);
        check("midrst_dac_data", 32'(dac_data), 32'h800);
        check("midrst_dac_valid", 32'(dac_valid), 32'h0);
        check("midrst_wr_data", 32'(wr_data), 32'h0);
        rst_n = 1'b1; dac_tick = 1'b0;
        cyc(1);
        read_check("midrst_status", 16'h4000, 16'h0000);
        read_check("ram_kept", 16'd5, 16'd5);
        read_check("undecoded", 16'h5000, 16'h0000);

        // Frame length clamping
        bus_write(16'h4001, 16'd0);
        read_check("len_zero", 16'h4001, 16'h0400);
        bus_write(16'h4001, 16'd2000);
        read_check("len_big", 16'h4001, 16'h0400);
        bus_write(16'h4001, 16'd5);
        read_check("len_five", 16'h4001, 16'h0005);

        check("sb_empty", 32'(exp_q.size()), 32'h0);
`ifdef PBUF_IRQ_EN
        // 3 wrap swaps + 2 start swaps + 2 underrun wraps
        check("irq_count", 32'(irq_cnt), 32'd7);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
